// File: rtl/fpm_operand_driver.sv
// -----------------------------------------------------------------------------
// fpm_operand_driver
//
// Purpose:
//   This is the initiator side of the floating-point multiplier's serial
//   operand interface. It accepts an operand pair {A,B} from an upstream
//   valid/ready stream. It sends A and then B over the multiplier's shared
//   32-bit number bus, using a separate valid/ready handshake for each
//   operand. When the multiplier raises result_valid, the block captures the
//   product and forwards it downstream on a valid/ready stream. If no product
//   arrives within TIMEOUT_CYCLES, the operation is abandoned and a sticky
//   error flag is set.
//
// Optional feature (macro FPM_DRV_CLASSIFY_EN):
//   Adds res_class[2:0]. This field is registered alongside res_data and
//   classifies the captured product:
//   0=zero, 1=subnormal, 2=normal, 3=infinity, 4=NaN.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   op_a, op_b        IEEE-754 single operands (upstream)
//   op_valid/op_ready upstream handshake
//   fpm_number_in     shared operand bus to the multiplier
//   fpm_a_valid/ready operand A handshake
//   fpm_b_valid/ready operand B handshake
//   fpm_number_out    product from the multiplier
//   fpm_result_valid  product valid (level, held until the next A transfer)
//   res_data          product to downstream
//   res_valid/ready   downstream handshake
//   timeout_err       sticky timeout flag, cleared only by rst
//   res_class         product class (only with FPM_DRV_CLASSIFY_EN)
// -----------------------------------------------------------------------------
module fpm_operand_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_valid,
  output logic        op_ready,
  output logic [31:0] fpm_number_in,
  output logic        fpm_a_valid,
  input  logic        fpm_a_ready,
  output logic        fpm_b_valid,
  input  logic        fpm_b_ready,
  input  logic [31:0] fpm_number_out,
  input  logic        fpm_result_valid,
  output logic [31:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        timeout_err
`ifdef FPM_DRV_CLASSIFY_EN
  ,
  output logic [2:0]  res_class
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND_A,
    S_SEND_B,
    S_WAIT_RES
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q,     state_d;
  logic [TO_W-1:0] cnt_q,       cnt_d;
  logic [31:0]     num_q,       num_d;       // value driven on the shared bus
  logic [31:0]     b_q,         b_d;         // B waits here while A is sent
  logic [31:0]     res_data_q,  res_data_d;
  logic            res_valid_q, res_valid_d;
  logic            op_ready_q,  op_ready_d;
  logic            to_err_q,    to_err_d;

`ifdef FPM_DRV_CLASSIFY_EN
  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_NAN  = 3'd4;

  logic [2:0] res_class_q, res_class_d;

  function automatic logic [2:0] classify(input logic [31:0] f);
    logic [7:0]  e;
    logic [22:0] m;
    e = f[30:23];
    m = f[22:0];
    if (e == 8'h00)      return (m == '0) ? CLS_ZERO : CLS_SUB;
    else if (e == 8'hFF) return (m == '0) ? CLS_INF  : CLS_NAN;
    else                 return CLS_NORM;
  endfunction
`endif

  // Operand valids depend combinationally on ready. The multiplier samples
  // valid and drops ready on the same edge, so each valid is high for
  // exactly one cycle.
  assign fpm_a_valid   = (state_q == S_SEND_A) && fpm_a_ready;
  assign fpm_b_valid   = (state_q == S_SEND_B) && fpm_b_ready;
  assign fpm_number_in = num_q;
  assign op_ready      = op_ready_q;
  assign res_data      = res_data_q;
  assign res_valid     = res_valid_q;
  assign timeout_err   = to_err_q;

  always_comb begin
    // NOTE: every signal gets a default before the case; a path that left
    // one unassigned would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    b_d         = b_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    to_err_d    = to_err_q;
`ifdef FPM_DRV_CLASSIFY_EN
    res_class_d = res_class_q;
`endif

    // A drain empties the output register. A capture later in this block
    // overrides the drain, which covers the simultaneous drain-and-replace
    // case.
    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // op_ready_q is low for the first cycle after reset, so accepting on
        // the registered ready keeps that cycle closed.
        if (op_valid && op_ready_q) begin
          num_d   = op_a;
          b_d     = op_b;
          state_d = S_SEND_A;
        end
      end
      S_SEND_A: begin
        if (fpm_a_ready) begin
          num_d   = b_q;
          state_d = S_SEND_B;
        end
      end
      S_SEND_B: begin
        if (fpm_b_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        // result_valid is only looked at here. A stale level left over from
        // the previous product has already dropped by the time A is taken.
        if (fpm_result_valid) begin
          // If the output register is full and not draining, stall with the
          // counter frozen.
          if (!res_valid_q || res_ready) begin
            res_data_d  = fpm_number_out;
            res_valid_d = 1'b1;
`ifdef FPM_DRV_CLASSIFY_EN
            res_class_d = classify(fpm_number_out);
`endif
            state_d     = S_IDLE;
          end
        end else if (cnt_q == TO_LAST) begin
          to_err_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    op_ready_d = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // here is a small control or data register, so all of them are reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      b_q         <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      op_ready_q  <= 1'b0;
      to_err_q    <= 1'b0;
`ifdef FPM_DRV_CLASSIFY_EN
      res_class_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      b_q         <= b_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      op_ready_q  <= op_ready_d;
      to_err_q    <= to_err_d;
`ifdef FPM_DRV_CLASSIFY_EN
      res_class_q <= res_class_d;
`endif
    end
  end

`ifdef FPM_DRV_CLASSIFY_EN
  assign res_class = res_class_q;
`endif

endmodule

// File: tb/tb_fpm_operand_driver.sv
// -----------------------------------------------------------------------------
// tb_fpm_operand_driver
//
// Bench for fpm_operand_driver. A behavioural multiplier model accepts A and
// B and then returns a hand-computed product after a programmable latency.
// The stimulus pushes each expected product into a scoreboard queue. A
// monitor process pops the queue and compares whenever the downstream
// handshake fires. The monitor also checks that res_data stays stable under
// backpressure.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fpm_operand_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op_a, op_b;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] fpm_number_in;
  logic        fpm_a_valid, fpm_a_ready;
  logic        fpm_b_valid, fpm_b_ready;
  logic [31:0] fpm_number_out;
  logic        fpm_result_valid;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        timeout_err;
`ifdef FPM_DRV_CLASSIFY_EN
  logic [2:0]  res_class;
`endif

  always #5 clk = ~clk;

  fpm_operand_driver #(.TIMEOUT_CYCLES(64), .TO_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .op_a             (op_a),
    .op_b             (op_b),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .fpm_number_in    (fpm_number_in),
    .fpm_a_valid      (fpm_a_valid),
    .fpm_a_ready      (fpm_a_ready),
    .fpm_b_valid      (fpm_b_valid),
    .fpm_b_ready      (fpm_b_ready),
    .fpm_number_out   (fpm_number_out),
    .fpm_result_valid (fpm_result_valid),
    .res_data         (res_data),
    .res_valid        (res_valid),
    .res_ready        (res_ready)
`ifdef FPM_DRV_CLASSIFY_EN
    ,
    .res_class        (res_class)
`endif
    ,
    .timeout_err      (timeout_err)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } mul_vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  cls;
  } exp_t;

  mul_vec_t mul_tbl[$];   // operands the multiplier model expects, with the product to return
  exp_t     sb[$];        // scoreboard of expected downstream results

  // ------------------------------------------------------- multiplier model
  typedef enum {M_A, M_B, M_CALC} mst_e;
  mst_e        m_st;
  int          m_cnt;
  int          m_lat     = 0;
  bit          no_result = 1'b0;
  logic        m_rst     = 1'b0;
  logic [31:0] m_prod;
  int          cyc   = 0;
  int          b_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge m_rst) begin
    if (m_rst) begin
      m_st             <= M_A;
      fpm_a_ready      <= 1'b1;
      fpm_b_ready      <= 1'b0;
      fpm_result_valid <= 1'b0;
      fpm_number_out   <= '0;
      m_cnt            <= 0;
      m_prod           <= '0;
    end else begin
      case (m_st)
        M_A: if (fpm_a_valid && fpm_a_ready) begin
          if (mul_tbl.size() == 0) fail("mul_unexpected_a");
          else check("bus_a", fpm_number_in, mul_tbl[0].a);
          fpm_a_ready      <= 1'b0;
          fpm_b_ready      <= 1'b1;
          fpm_result_valid <= 1'b0;
          m_st             <= M_B;
        end
        M_B: if (fpm_b_valid && fpm_b_ready) begin
          if (mul_tbl.size() == 0) fail("mul_unexpected_b");
          else begin
            check("bus_b", fpm_number_in, mul_tbl[0].b);
            m_prod <= mul_tbl[0].p;
            void'(mul_tbl.pop_front());
          end
          fpm_b_ready <= 1'b0;
          m_cnt       <= m_lat;
          b_cyc       <= cyc;
          m_st        <= M_CALC;
        end
        M_CALC: if (!no_result) begin
          if (m_cnt == 0) begin
            fpm_number_out   <= m_prod;
            fpm_result_valid <= 1'b1;
            fpm_a_ready      <= 1'b1;
            m_st             <= M_A;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
        default: m_st <= M_A;
      endcase
    end
  end

  // ----------------------------------------------------------------- monitor
  int          a_pulses  = 0;
  int          b_pulses  = 0;
  int          rv_cycles = 0;
  bit          hold_prev = 1'b0;
  logic [31:0] hold_data;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst !== 1'b0) begin
        hold_prev = 1'b0;
        continue;
      end
      if (fpm_a_valid) a_pulses++;
      if (fpm_b_valid) b_pulses++;
      if (res_valid)   rv_cycles++;
      if (hold_prev) begin
        check("hold_valid", {31'b0, res_valid}, 32'd1);
        check("hold_data", res_data, hold_data);
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) fail("unexpected_result");
        else begin
          exp_t e;
          e = sb.pop_front();
          check("res_data", res_data, e.data);
`ifdef FPM_DRV_CLASSIFY_EN
          check("res_class", {29'b0, res_class}, {29'b0, e.cls});
`endif
        end
      end
      hold_prev = res_valid && !res_ready;
      hold_data = res_data;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                         input bit expect_res, input logic [2:0] cls);
    mul_vec_t v;
    exp_t     e;
    bit       accepted;
    v.a = a;
    v.b = b;
    v.p = p;
    mul_tbl.push_back(v);
    if (expect_res) begin
      e.data = p;
      e.cls  = cls;
      sb.push_back(e);
    end
    accepted = 1'b0;
    @(negedge clk);
    op_a     = a;
    op_b     = b;
    op_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (op_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) fail("op_accept_timeout");
    else @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !res_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail("drain_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int pa, pb, prv;
    bit found;

    op_a      = '0;
    op_b      = '0;
    op_valid  = 1'b0;
    res_ready = 1'b0;
    rst       = 1'b1;
    #1 m_rst = 1'b1;
    #1 m_rst = 1'b0;

    // Reset state
    wait_cycles(2);
    #1;
    check("rst_ctrl", {27'b0, op_ready, fpm_a_valid, fpm_b_valid, res_valid, timeout_err}, 32'd0);
    check("rst_bus", fpm_number_in, 32'd0);
    check("rst_res_data", res_data, 32'd0);
`ifdef FPM_DRV_CLASSIFY_EN
    check("rst_res_class", {29'b0, res_class}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);
    check("idle_op_ready", {31'b0, op_ready}, 32'd1);

    // 2.0 x 3.0 = 6.0: one A pulse, one B pulse, res_valid high one cycle
    res_ready = 1'b1;
    m_lat     = 0;
    pa  = a_pulses;
    pb  = b_pulses;
    prv = rv_cycles;
    send_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1, 3'd2);
    wait_drain(100);
    check("t1_a_pulses", a_pulses - pa, 32'd1);
    check("t1_b_pulses", b_pulses - pb, 32'd1);
    check("t1_res_valid_cycles", rv_cycles - prv, 32'd1);
    check("t1_timeout_err", {31'b0, timeout_err}, 32'd0);

    // 1.5 x -2.0 = -3.0 (normal)
    send_op(32'h3FC0_0000, 32'hC000_0000, 32'hC040_0000, 1'b1, 3'd2);
    wait_drain(100);

    // inf x 0 = NaN
    send_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1, 3'd4);
    wait_drain(100);

    // Backpressure: first result held; second op stalls well past the timeout
    res_ready = 1'b0;
    m_lat     = 2;
    send_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1, 3'd2);
    send_op(32'h3FC0_0000, 32'hC000_0000, 32'hC040_0000, 1'b1, 3'd2);
    wait_cycles(150);
    check("bp_res_valid", {31'b0, res_valid}, 32'd1);
    check("bp_res_data", res_data, 32'h40C0_0000);
    check("bp_no_timeout", {31'b0, timeout_err}, 32'd0);
    check("bp_op_ready", {31'b0, op_ready}, 32'd0);
    check("bp_sb_depth", sb.size(), 32'd2);
    res_ready = 1'b1;
    wait_drain(50);

    // Timeout: the multiplier never answers
    no_result = 1'b1;
    send_op(32'h4000_0000, 32'h4040_0000, 32'h0, 1'b0, 3'd0);
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (timeout_err) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail("timeout_never_set");
    else check("timeout_latency", cyc - b_cyc - 1, 32'd64);
    check("to_op_ready", {31'b0, op_ready}, 32'd1);
    check("to_res_valid", {31'b0, res_valid}, 32'd0);
    no_result = 1'b0;
    m_rst = 1'b1;
    #1 m_rst = 1'b0;
    wait_cycles(5);
    check("to_sticky", {31'b0, timeout_err}, 32'd1);

    // Reset while in WAIT_RES; the late product must be discarded
    m_lat = 20;
    send_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 3'd0);
    wait_cycles(4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ctrl", {27'b0, op_ready, fpm_a_valid, fpm_b_valid, res_valid, timeout_err}, 32'd0);
    check("mid_rst_bus", fpm_number_in, 32'd0);
    check("mid_rst_res_data", res_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(40);
    check("post_rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("post_rst_res_data", res_data, 32'd0);
    check("post_rst_op_ready", {31'b0, op_ready}, 32'd1);

    // Stale result_valid (still high, carrying 6.0) must not be captured
    m_lat = 3;
    send_op(32'h3FC0_0000, 32'hC000_0000, 32'hC040_0000, 1'b1, 3'd2);
    wait_drain(100);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
